// File: rtl/wavetable_rom_arbiter_if.sv
// Bus bundle between the voice requesters, the arbiter and the dual-port wavetable ROM.
// The master side is the requesters plus the ROM; the slave side is the arbiter.
interface wavetable_rom_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ*DATA_W-1:0] rdata;
  logic [NUM_REQ-1:0]        rdata_valid;
  logic                      rom_re_a;
  logic                      rom_re_b;
  logic [ADDR_W-1:0]         rom_addr_a;
  logic [ADDR_W-1:0]         rom_addr_b;
  logic [DATA_W-1:0]         rom_data_a;
  logic [DATA_W-1:0]         rom_data_b;

  modport master (
    output req, req_addr, rom_data_a, rom_data_b,
    input  gnt, rdata, rdata_valid, rom_re_a, rom_re_b, rom_addr_a, rom_addr_b
  );

  modport slave (
    input  req, req_addr, rom_data_a, rom_data_b,
    output gnt, rdata, rdata_valid, rom_re_a, rom_re_b, rom_addr_a, rom_addr_b
  );
endinterface

// File: rtl/wavetable_rom_arbiter.sv
// Round-robin arbiter sharing the two ROM read ports among NUM_REQ requesters,
// with a tag pipeline that steers each returned byte to its owner.
module wavetable_rom_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wavetable_rom_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] id_t;

  id_t                ptr;
  id_t                cand;
  id_t                win_a;
  id_t                win_b;
  logic               hit_a;
  logic               hit_b;
  logic               vld_a;
  logic               vld_b;
  id_t                id_a;
  id_t                id_b;
  logic [NUM_REQ-1:0] gnt_c;
  logic [NUM_REQ-1:0] valid_q;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_q   [NUM_REQ];

  function automatic id_t wrap_inc(input id_t base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return id_t'(s);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slices
    assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign bus.rdata[i*DATA_W +: DATA_W] = data_q[i];
  end

  // Scan from ptr with wraparound; first pending request takes port A, second port B.
  // Gating with rst_n keeps the ROM pins quiet while reset is held.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    win_a = '0;
    win_b = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_inc(ptr, k);
      if (rst_n && bus.req[cand]) begin
        if (!hit_a) begin
          hit_a = 1'b1;
          win_a = cand;
        end else if (!hit_b) begin
          hit_b = 1'b1;
          win_b = cand;
        end
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (hit_a) gnt_c[win_a] = 1'b1;
    if (hit_b) gnt_c[win_b] = 1'b1;
  end

  assign bus.gnt        = gnt_c;
  assign bus.rom_re_a   = hit_a;
  assign bus.rom_re_b   = hit_b;
  assign bus.rom_addr_a = hit_a ? addr_arr[win_a] : '0;
  assign bus.rom_addr_b = hit_b ? addr_arr[win_b] : '0;

  // Priority moves just past the last winner so every requester is reached within ceil(N/2) cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      vld_a <= 1'b0;
      vld_b <= 1'b0;
      id_a  <= '0;
      id_b  <= '0;
    end else begin
      vld_a <= hit_a;
      vld_b <= hit_b;
      id_a  <= win_a;
      id_b  <= win_b;
      if (hit_b)      ptr <= wrap_inc(win_b, 1);
      else if (hit_a) ptr <= wrap_inc(win_a, 1);
    end
  end

  // The two tags of one cycle always name different requesters, so both writes can land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) data_q[i] <= '0;
    end else begin
      valid_q <= '0;
      if (vld_a) begin
        data_q[id_a]  <= bus.rom_data_a;
        valid_q[id_a] <= 1'b1;
      end
      if (vld_b) begin
        data_q[id_b]  <= bus.rom_data_b;
        valid_q[id_b] <= 1'b1;
      end
    end
  end

  assign bus.rdata_valid = valid_q;
endmodule

// File: doc/wavetable_rom_arbiter.md
# wavetable_rom_arbiter

Round-robin read arbiter that shares the two read ports of the dual-port wavetable data ROM among NUM_REQ requesters, typically the voice oscillators. Each cycle it grants up to two pending requests, port A to the first and port B to the second, tags each issued read, and returns the ROM byte to the owning requester on a registered per-requester data output with a one-cycle valid pulse. It sits between the voice engines and the ROM and owns the ROM's read-enable and address pins.

## Interface
Parameters:
- NUM_REQ, 8, number of requesters; 2..16.
- ADDR_W, 10, ROM address width.
- DATA_W, 8, ROM data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester read request; held with address stable until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  combinational one-cycle grant; read issued this cycle.
- rdata  out  NUM_REQ*DATA_W  registered per-requester read data; holds until next return.
- rdata_valid  out  NUM_REQ  one-cycle pulse; rdata slice updated this cycle.
- rom_re_a / rom_re_b  out  1  ROM port read enables (combinational).
- rom_addr_a / rom_addr_b  out  ADDR_W  ROM port addresses (combinational; 0 when re low).
- rom_data_a / rom_data_b  in  DATA_W  ROM registered outputs, valid one cycle after re.

## Operation
- Round-robin pointer ptr (log2 NUM_REQ bits) names the highest-priority requester.
- Cycle t: scan req starting at ptr, wrapping past NUM_REQ-1 to 0. First set bit = winner A, second = winner B.
- Winner A drives rom_re_a=1, rom_addr_a=its address, gnt bit=1. Winner B does the same on port B.
- Only one request: port A only; rom_re_b=0. No request: both re=0, gnt=0.
- A requester receives at most one grant per cycle. It may keep req high after gnt to issue the next read; that request is arbitrated again from t+1.
- ptr update at end of t if any grant: ptr <= (index of last winner + 1) mod NUM_REQ. With no grant, ptr holds.
- Tag pipeline: at end of t, register {vld_a, id_a} and {vld_b, id_b}.
- Cycle t+1: the ROM presents its data. At end of t+1, rdata[id_a] <= rom_data_a if vld_a, and rdata[id_b] <= rom_data_b if vld_b. The corresponding rdata_valid bits are registered high for cycle t+2 only.
- id_a and id_b never match, so no write collision on rdata.
- Addresses pass unmodified; no range check. Out-of-range behaviour is the ROM's.

## Timing
- Grant to rdata_valid: 2 cycles. gnt in cycle t, valid and data in cycle t+2.
- Throughput: 2 reads/cycle sustained.
- Worst-case wait with all NUM_REQ requesting: ceil(NUM_REQ/2) cycles.
- While rst_n is low, gnt, rom_re_a/b and rom_addr_a/b are forced to 0.
- Reset values: ptr=0, tag valids=0, rdata=0, rdata_valid=0.
- Reset mid-flight: in-flight tags are discarded. No rdata_valid pulse follows reset release. First grant is possible in the first cycle with rst_n high.
- A req deasserted in the same cycle it would win is simply not granted. No glitch is required of the requester.

## Test plan
ROM model for all scenarios: rom_data = addr[7:0] ^ 8'hA5, one-cycle latency; NUM_REQ=8.
- Reset: hold rst_n=0 with random req -> gnt, rom_re_a/b, rdata, rdata_valid all 0. After release with req=0 -> outputs stay 0.
- Single read: req[3]=1, addr 10'h005 in cycle t -> gnt[3] in t, rom_re_a=1, rom_addr_a=5, rom_re_b=0. rdata_valid[3] in t+2 with rdata[3]=8'hA0. ptr becomes 4.
- Three simultaneous: req[0..2] with addrs 1,2,3 in t -> t: gnt 0(A), 1(B). t+1: gnt 2(A). rdata_valid[0],[1] in t+2 with A4, A7. rdata_valid[2] in t+3 with A6.
- Fairness and wrap: all 8 req held high for 16 cycles -> grant pairs (0,1),(2,3),(4,5),(6,7),(0,1)... Each requester granted exactly 4 times; ptr wraps 6->0.
- Pointer priority: ptr=6, req[1],[6],[7] set -> A=6, B=7, then next cycle A=1. ptr ends at 2.
- Reset mid-flight: grants in t, rst_n low in t+1 -> no rdata_valid in t+2 or later. rdata=0. ptr=0 after release.
